y86_execute: RTL

- Execute stage of the sequential Y86-64 core.
- Sits between decode/writeback (which supplies valA/valB and consumes valE/cnd) and the memory stage.
- Computes valE, holds the condition-code register (ZF/SF/OF), evaluates cnd for jXX/cmovXX, and runs the sticky processor-status machine (AOK/HLT/ADR/INS) that gates all architectural updates.

---
 rtl/y86_pkg.sv | 25 ++
 rtl/y86_execute_if.sv | 38 +++
 rtl/y86_alu.sv | 38 +++
 rtl/y86_execute.sv | 125 ++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 execute-stage encodings: icodes, ALU functions, condition codes, status.
package y86_pkg;

    localparam int unsigned CC_W = 3;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR} alu_fn_e;

    typedef enum logic [3:0] {C_ALW, C_LE, C_L, C_E, C_NE, C_GE, C_G} cond_e;

    typedef enum logic [1:0] {S_AOK, S_HLT, S_ADR, S_INS} stat_e;

endpackage

// File: rtl/y86_execute_if.sv
// Decode/fetch <-> execute bus. Optional perf counters appear when Y86_EXEC_PERF_EN is defined.
interface y86_execute_if #(parameter int unsigned DATA_W = 64);

    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic              instr_valid;
    logic              imem_error;
    logic              dmem_error;
    logic [DATA_W-1:0] valA;
    logic [DATA_W-1:0] valB;
    logic [DATA_W-1:0] valC;
    logic [DATA_W-1:0] valE;
    logic              cnd;
    logic [2:0]        cc;
    logic [1:0]        stat;
    logic              run;
`ifdef Y86_EXEC_PERF_EN
    logic [63:0]       cycle_cnt;
    logic [63:0]       instr_cnt;
`endif

    modport master (
        output icode, ifun, instr_valid, imem_error, dmem_error, valA, valB, valC,
        input  valE, cnd, cc, stat, run
`ifdef Y86_EXEC_PERF_EN
        , input cycle_cnt, instr_cnt
`endif
    );

    modport slave (
        input  icode, ifun, instr_valid, imem_error, dmem_error, valA, valB, valC,
        output valE, cnd, cc, stat, run
`ifdef Y86_EXEC_PERF_EN
        , output cycle_cnt, instr_cnt
`endif
    );

endinterface

// File: rtl/y86_alu.sv
// Combinational Y86 ALU: result = b <fn> a, with zero/sign/overflow flags.
module y86_alu
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_fn_e           fn,
    output logic [DATA_W-1:0] result,
    output logic              zf,
    output logic              sf,
    output logic              of
);

    localparam int unsigned MSB = DATA_W - 1;

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (fn)
            ALU_ADD: begin
                result = b + a;
                of     = (a[MSB] == b[MSB]) && (result[MSB] != b[MSB]);
            end
            ALU_SUB: begin
                result = b - a;
                of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
            end
            ALU_AND: result = b & a;
            ALU_XOR: result = b ^ a;
            default: result = '0;
        endcase
        zf = (result == '0);
        sf = result[MSB];
    end

endmodule

// File: rtl/y86_execute.sv
// Y86-64 execute stage: valE, condition codes, cnd and sticky status FSM.
// Define Y86_EXEC_PERF_EN to add cycle_cnt/instr_cnt performance counters.
module y86_execute
    import y86_pkg::*;
#(
    parameter int unsigned    DATA_W = 64,
    parameter logic [CC_W-1:0] CC_RST = 3'b100
) (
    input  logic          clk,
    input  logic          rst,
    y86_execute_if.slave  bus
);

    logic [DATA_W-1:0] alu_a, alu_b, alu_res;
    alu_fn_e           alu_fn;
    logic              alu_zf, alu_sf, alu_of;
    stat_e             stat_q, stat_d;
    logic              run_q;
    logic [CC_W-1:0]   cc_q;
    logic              err_adr, err_ins, cc_we, cnd_c;

    // Operand routing so one adder/logic unit serves every icode
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fn = ALU_ADD;
        case (bus.icode)
            I_CMOV:                 begin alu_a = bus.valA; alu_b = bus.valB; end
            I_IRMOV, I_RMMOV,
            I_MRMOV:                begin alu_a = bus.valC; alu_b = bus.valB; end
            I_OPQ: begin
                alu_a  = bus.valA;
                alu_b  = bus.valB;
                alu_fn = alu_fn_e'(bus.ifun[1:0]);
            end
            I_CALL, I_PUSH: begin
                alu_a  = DATA_W'(8);
                alu_b  = bus.valB;
                alu_fn = ALU_SUB;
            end
            I_RET, I_POP:           begin alu_a = DATA_W'(8); alu_b = bus.valB; end
            default: ;
        endcase
    end

    y86_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_res),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    assign err_adr = bus.imem_error | bus.dmem_error;
    assign err_ins = !bus.instr_valid
                   || (bus.icode == I_OPQ && bus.ifun > 4'd3)
                   || ((bus.icode == I_CMOV || bus.icode == I_JXX) && bus.ifun > 4'd6);

    // Status next-state; non-AOK states are left only through rst
    always_comb begin
        stat_d = stat_q;
        cc_we  = 1'b0;
        if (stat_q == S_AOK) begin
            if (err_adr)                  stat_d = S_ADR;
            else if (err_ins)             stat_d = S_INS;
            else if (bus.icode == I_HALT) stat_d = S_HLT;
            cc_we = !err_adr && !err_ins && (bus.icode == I_OPQ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= S_AOK;
            run_q  <= 1'b1;
            cc_q   <= CC_RST;
        end else begin
            stat_q <= stat_d;
            run_q  <= (stat_d == S_AOK);
            if (cc_we) cc_q <= {alu_zf, alu_sf, alu_of};
        end
    end

    // Branch/cmov condition from the committed flags {ZF,SF,OF}
    always_comb begin
        cnd_c = 1'b0;
        if (run_q && (bus.icode == I_CMOV || bus.icode == I_JXX)) begin
            case (bus.ifun)
                C_ALW:   cnd_c = 1'b1;
                C_LE:    cnd_c = (cc_q[1] ^ cc_q[0]) | cc_q[2];
                C_L:     cnd_c = cc_q[1] ^ cc_q[0];
                C_E:     cnd_c = cc_q[2];
                C_NE:    cnd_c = !cc_q[2];
                C_GE:    cnd_c = !(cc_q[1] ^ cc_q[0]);
                C_G:     cnd_c = !(cc_q[1] ^ cc_q[0]) && !cc_q[2];
                default: cnd_c = 1'b0;
            endcase
        end
    end

    assign bus.valE = alu_res;
    assign bus.cnd  = cnd_c;
    assign bus.cc   = cc_q;
    assign bus.stat = stat_q;
    assign bus.run  = run_q;

`ifdef Y86_EXEC_PERF_EN
    logic [63:0] cycle_cnt_q, instr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else if (run_q) begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
            if (!err_adr && !err_ins) instr_cnt_q <= instr_cnt_q + 64'd1;
        end
    end

    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
`endif

endmodule
